// File: rtl/wb_writeback_stage.sv
// rtl/wb_writeback_stage.sv - write-back stage: load extract, GPR/CSR write buses, retire count, halt FSM
module wb_writeback_stage #(
  parameter int                BITS_W      = 64,
  parameter int                INST_W      = 32,
  parameter int                GPR_W       = 5,
  parameter int                CSR_W       = 12,
  parameter logic [CSR_W-1:0]  CSR_MEPC    = 12'h341,
  parameter logic [CSR_W-1:0]  CSR_MCAUSE  = 12'h342,
  parameter logic [BITS_W-1:0] ECALL_CAUSE = 64'd11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_i_valid,
  output logic              WB_o_ready,
  input  logic [BITS_W-1:0] MEM_i_pc,
  input  logic [INST_W-1:0] MEM_i_inst,
  input  logic [GPR_W-1:0]  MEM_i_rd,
  input  logic              MEM_i_write_gpr,
  input  logic              MEM_i_mem_to_reg,
  input  logic [BITS_W-1:0] MEM_i_alu_result,
  input  logic [BITS_W-1:0] MEM_i_mem_rdata,
  input  logic              MEM_i_mem_byte,
  input  logic              MEM_i_mem_half,
  input  logic              MEM_i_mem_word,
  input  logic              MEM_i_mem_dword,
  input  logic              MEM_i_mem_byte_u,
  input  logic              MEM_i_mem_half_u,
  input  logic              MEM_i_mem_word_u,
  input  logic [CSR_W-1:0]  MEM_i_csr_rd_1,
  input  logic [CSR_W-1:0]  MEM_i_csr_rd_2,
  input  logic              MEM_i_write_csr_1,
  input  logic              MEM_i_write_csr_2,
  input  logic [BITS_W-1:0] MEM_i_csr_wdata,
  input  logic [BITS_W-1:0] MEM_i_csr_rdata,
  input  logic              MEM_i_rv64_csrrw,
  input  logic              MEM_i_rv64_csrrs,
  input  logic              MEM_i_rv64_ecall,
  input  logic              MEM_i_system_halt,
  input  logic              MEM_i_commit,
  output logic [GPR_W-1:0]  WB_o_rd,
  output logic              WB_o_RegWr,
  output logic [BITS_W-1:0] WB_o_rf_busW,
  output logic [CSR_W-1:0]  WB_o_csr_rd_1,
  output logic [CSR_W-1:0]  WB_o_csr_rd_2,
  output logic              WB_o_CSRWr_1,
  output logic              WB_o_CSRWr_2,
  output logic [BITS_W-1:0] WB_o_csr_busW_1,
  output logic [BITS_W-1:0] WB_o_csr_busW_2,
  output logic [BITS_W-1:0] WB_o_pc,
  output logic [INST_W-1:0] WB_o_inst,
  output logic              WB_o_commit,
  output logic [63:0]       WB_o_retire_cnt,
  output logic              WB_o_halt
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t              r_state;
  logic                r_ready;
  logic                r_halt;
  logic                r_valid;
  logic [BITS_W-1:0]   r_pc;
  logic [INST_W-1:0]   r_inst;
  logic [GPR_W-1:0]    r_rd;
  logic                r_write_gpr;
  logic                r_mem_to_reg;
  logic [BITS_W-1:0]   r_alu_result;
  logic [BITS_W-1:0]   r_mem_rdata;
  logic [6:0]          r_size;        // {byte, half, word, dword, byte_u, half_u, word_u}
  logic [CSR_W-1:0]    r_csr_rd_1;
  logic [CSR_W-1:0]    r_csr_rd_2;
  logic                r_write_csr_1;
  logic                r_write_csr_2;
  logic [BITS_W-1:0]   r_csr_wdata;
  logic [BITS_W-1:0]   r_csr_rdata;
  logic                r_csrrw;
  logic                r_csrrs;
  logic                r_ecall;
  logic                r_system_halt;
  logic                r_commit;
  logic [63:0]         r_retire_cnt;

  logic                w_retire;
  logic                w_halting;
  logic                w_transfer;
  logic [2:0]          w_off;
  logic [BITS_W-1:0]   w_sh_b;
  logic [BITS_W-1:0]   w_sh_h;
  logic [BITS_W-1:0]   w_sh_w;
  logic [BITS_W-1:0]   w_load;

  assign w_retire  = r_valid & r_commit;
  assign w_halting = w_retire & r_system_halt;
  // The edge that retires a halting instruction also enters HALT, so nothing
  // offered in that same cycle may be captured.
  assign w_transfer = MEM_i_valid & r_ready & ~w_halting;

  // Halt FSM: RUN until a committed halt retires, then HALT until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_ready <= 1'b1;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_halting) begin
            r_state <= S_HALT;
            r_ready <= 1'b0;
            r_halt  <= 1'b1;
          end
        end
        S_HALT: begin
          r_ready <= 1'b0;
          r_halt  <= 1'b1;
        end
        default: begin
          r_state <= S_RUN;
          r_ready <= 1'b1;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  // Stage register: capture the MEM payload on a transfer, otherwise go idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_inst        <= '0;
      r_rd          <= '0;
      r_write_gpr   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_result  <= '0;
      r_mem_rdata   <= '0;
      r_size        <= '0;
      r_csr_rd_1    <= '0;
      r_csr_rd_2    <= '0;
      r_write_csr_1 <= 1'b0;
      r_write_csr_2 <= 1'b0;
      r_csr_wdata   <= '0;
      r_csr_rdata   <= '0;
      r_csrrw       <= 1'b0;
      r_csrrs       <= 1'b0;
      r_ecall       <= 1'b0;
      r_system_halt <= 1'b0;
      r_commit      <= 1'b0;
    end else begin
      r_valid <= w_transfer;
      if (w_transfer) begin
        r_pc          <= MEM_i_pc;
        r_inst        <= MEM_i_inst;
        r_rd          <= MEM_i_rd;
        r_write_gpr   <= MEM_i_write_gpr;
        r_mem_to_reg  <= MEM_i_mem_to_reg;
        r_alu_result  <= MEM_i_alu_result;
        r_mem_rdata   <= MEM_i_mem_rdata;
        r_size        <= {MEM_i_mem_byte, MEM_i_mem_half, MEM_i_mem_word, MEM_i_mem_dword,
                          MEM_i_mem_byte_u, MEM_i_mem_half_u, MEM_i_mem_word_u};
        r_csr_rd_1    <= MEM_i_csr_rd_1;
        r_csr_rd_2    <= MEM_i_csr_rd_2;
        r_write_csr_1 <= MEM_i_write_csr_1;
        r_write_csr_2 <= MEM_i_write_csr_2;
        r_csr_wdata   <= MEM_i_csr_wdata;
        r_csr_rdata   <= MEM_i_csr_rdata;
        r_csrrw       <= MEM_i_rv64_csrrw;
        r_csrrs       <= MEM_i_rv64_csrrs;
        r_ecall       <= MEM_i_rv64_ecall;
        r_system_halt <= MEM_i_system_halt;
        r_commit      <= MEM_i_commit;
      end
    end
  end

  // Retire counter advances as a committed instruction is captured, so the
  // count shown alongside a commit pulse already includes that instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_transfer & MEM_i_commit) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  // Lane shifts: misaligned half/word accesses use the truncated offset
  assign w_off  = r_alu_result[2:0];
  assign w_sh_b = r_mem_rdata >> {w_off, 3'b000};
  assign w_sh_h = r_mem_rdata >> {w_off[2:1], 4'b0000};
  assign w_sh_w = r_mem_rdata >> {w_off[2], 5'b00000};

  // Load extraction and sign/zero extension by access size
  always_comb begin
    w_load = r_mem_rdata;
    if (r_size[6])      w_load = {{(BITS_W-8){w_sh_b[7]}},   w_sh_b[7:0]};
    else if (r_size[5]) w_load = {{(BITS_W-16){w_sh_h[15]}}, w_sh_h[15:0]};
    else if (r_size[4]) w_load = {{(BITS_W-32){w_sh_w[31]}}, w_sh_w[31:0]};
    else if (r_size[3]) w_load = r_mem_rdata;
    else if (r_size[2]) w_load = {{(BITS_W-8){1'b0}},  w_sh_b[7:0]};
    else if (r_size[1]) w_load = {{(BITS_W-16){1'b0}}, w_sh_h[15:0]};
    else if (r_size[0]) w_load = {{(BITS_W-32){1'b0}}, w_sh_w[31:0]};
  end

  // GPR result select: load path, then old CSR value, then ALU
  always_comb begin
    WB_o_rf_busW = r_alu_result;
    if (r_mem_to_reg)            WB_o_rf_busW = w_load;
    else if (r_csrrw | r_csrrs)  WB_o_rf_busW = r_csr_rdata;
  end

  // CSR write group: ecall writes mepc/mcause, otherwise the decoded CSR ports
  always_comb begin
    WB_o_csr_rd_1   = r_csr_rd_1;
    WB_o_csr_rd_2   = r_csr_rd_2;
    WB_o_CSRWr_1    = w_retire & r_write_csr_1;
    WB_o_CSRWr_2    = w_retire & r_write_csr_2;
    WB_o_csr_busW_1 = r_csr_wdata;
    WB_o_csr_busW_2 = '0;
    if (r_ecall) begin
      WB_o_csr_rd_1   = CSR_MEPC;
      WB_o_csr_rd_2   = CSR_MCAUSE;
      WB_o_CSRWr_1    = w_retire;
      WB_o_CSRWr_2    = w_retire;
      WB_o_csr_busW_1 = r_pc;
      WB_o_csr_busW_2 = ECALL_CAUSE;
    end
  end

  assign WB_o_ready      = r_ready;
  assign WB_o_halt       = r_halt;
  assign WB_o_rd         = r_rd;
  assign WB_o_RegWr      = w_retire & r_write_gpr & (r_rd != '0);
  assign WB_o_pc         = r_pc;
  assign WB_o_inst       = r_inst;
  assign WB_o_commit     = w_retire;
  assign WB_o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_writeback_stage.sv
// tb/tb_wb_writeback_stage.sv - self-checking bench for wb_writeback_stage
module tb_wb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_i_valid;
  logic        WB_o_ready;
  logic [63:0] MEM_i_pc;
  logic [31:0] MEM_i_inst;
  logic [4:0]  MEM_i_rd;
  logic        MEM_i_write_gpr, MEM_i_mem_to_reg;
  logic [63:0] MEM_i_alu_result, MEM_i_mem_rdata;
  logic        MEM_i_mem_byte, MEM_i_mem_half, MEM_i_mem_word, MEM_i_mem_dword;
  logic        MEM_i_mem_byte_u, MEM_i_mem_half_u, MEM_i_mem_word_u;
  logic [11:0] MEM_i_csr_rd_1, MEM_i_csr_rd_2;
  logic        MEM_i_write_csr_1, MEM_i_write_csr_2;
  logic [63:0] MEM_i_csr_wdata, MEM_i_csr_rdata;
  logic        MEM_i_rv64_csrrw, MEM_i_rv64_csrrs, MEM_i_rv64_ecall;
  logic        MEM_i_system_halt, MEM_i_commit;
  logic [4:0]  WB_o_rd;
  logic        WB_o_RegWr;
  logic [63:0] WB_o_rf_busW;
  logic [11:0] WB_o_csr_rd_1, WB_o_csr_rd_2;
  logic        WB_o_CSRWr_1, WB_o_CSRWr_2;
  logic [63:0] WB_o_csr_busW_1, WB_o_csr_busW_2;
  logic [63:0] WB_o_pc;
  logic [31:0] WB_o_inst;
  logic        WB_o_commit;
  logic [63:0] WB_o_retire_cnt;
  logic        WB_o_halt;

  always #5 clk = ~clk;

  wb_writeback_stage dut (
    .clk(clk), .rst(rst),
    .MEM_i_valid(MEM_i_valid), .WB_o_ready(WB_o_ready),
    .MEM_i_pc(MEM_i_pc), .MEM_i_inst(MEM_i_inst), .MEM_i_rd(MEM_i_rd),
    .MEM_i_write_gpr(MEM_i_write_gpr), .MEM_i_mem_to_reg(MEM_i_mem_to_reg),
    .MEM_i_alu_result(MEM_i_alu_result), .MEM_i_mem_rdata(MEM_i_mem_rdata),
    .MEM_i_mem_byte(MEM_i_mem_byte), .MEM_i_mem_half(MEM_i_mem_half),
    .MEM_i_mem_word(MEM_i_mem_word), .MEM_i_mem_dword(MEM_i_mem_dword),
    .MEM_i_mem_byte_u(MEM_i_mem_byte_u), .MEM_i_mem_half_u(MEM_i_mem_half_u),
    .MEM_i_mem_word_u(MEM_i_mem_word_u),
    .MEM_i_csr_rd_1(MEM_i_csr_rd_1), .MEM_i_csr_rd_2(MEM_i_csr_rd_2),
    .MEM_i_write_csr_1(MEM_i_write_csr_1), .MEM_i_write_csr_2(MEM_i_write_csr_2),
    .MEM_i_csr_wdata(MEM_i_csr_wdata), .MEM_i_csr_rdata(MEM_i_csr_rdata),
    .MEM_i_rv64_csrrw(MEM_i_rv64_csrrw), .MEM_i_rv64_csrrs(MEM_i_rv64_csrrs),
    .MEM_i_rv64_ecall(MEM_i_rv64_ecall), .MEM_i_system_halt(MEM_i_system_halt),
    .MEM_i_commit(MEM_i_commit),
    .WB_o_rd(WB_o_rd), .WB_o_RegWr(WB_o_RegWr), .WB_o_rf_busW(WB_o_rf_busW),
    .WB_o_csr_rd_1(WB_o_csr_rd_1), .WB_o_csr_rd_2(WB_o_csr_rd_2),
    .WB_o_CSRWr_1(WB_o_CSRWr_1), .WB_o_CSRWr_2(WB_o_CSRWr_2),
    .WB_o_csr_busW_1(WB_o_csr_busW_1), .WB_o_csr_busW_2(WB_o_csr_busW_2),
    .WB_o_pc(WB_o_pc), .WB_o_inst(WB_o_inst), .WB_o_commit(WB_o_commit),
    .WB_o_retire_cnt(WB_o_retire_cnt), .WB_o_halt(WB_o_halt)
  );

  // sz: 1 lb, 2 lh, 3 lw, 4 ld, 5 lbu, 6 lhu, 7 lwu
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wgpr, m2r;
    logic [63:0] alu, rdata;
    int          sz;
    logic [11:0] csr1, csr2;
    logic        wcsr1, wcsr2, csrrw, csrrs, ecall, halt, commit;
    logic [63:0] cwdata, crdata;
  } in_t;

  typedef struct {
    logic [4:0]  rd;
    logic        regwr;
    logic [63:0] busw;
    logic        csrwr1, csrwr2;
    logic [11:0] csr1, csr2;
    logic [63:0] cbus1, cbus2;
    logic        commit;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_cnt;
  vec_t        vecs[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t blank();
    in_t t;
    t = '{default: 0};
    return t;
  endfunction

  function automatic exp_t noexp();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  // Reference: load lanes by byte arithmetic on the offset, then result rules
  function automatic exp_t model(in_t t);
    exp_t        e;
    int          off;
    logic [63:0] b, h, w, ld;
    off = int'(t.alu % 64'd8);
    b = (t.rdata >> (8 * off)) & 64'hFF;
    h = (t.rdata >> (16 * (off / 2))) & 64'hFFFF;
    w = (t.rdata >> (32 * (off / 4))) & 64'hFFFF_FFFF;
    case (t.sz)
      1: ld = (b >= 64'h80)        ? (b | ~64'hFF)        : b;
      2: ld = (h >= 64'h8000)      ? (h | ~64'hFFFF)      : h;
      3: ld = (w >= 64'h8000_0000) ? (w | ~64'hFFFF_FFFF) : w;
      5: ld = b;
      6: ld = h;
      7: ld = w;
      default: ld = t.rdata;
    endcase
    e.rd     = t.rd;
    e.commit = t.commit;
    e.regwr  = t.commit && t.wgpr && (t.rd != 0);
    e.busw   = t.m2r ? ld : ((t.csrrw || t.csrrs) ? t.crdata : t.alu);
    if (t.ecall) begin
      e.csrwr1 = t.commit; e.csr1 = 12'h341; e.cbus1 = t.pc;
      e.csrwr2 = t.commit; e.csr2 = 12'h342; e.cbus2 = 64'd11;
    end else begin
      e.csrwr1 = t.commit && t.wcsr1; e.csr1 = t.csr1; e.cbus1 = t.cwdata;
      e.csrwr2 = t.commit && t.wcsr2; e.csr2 = t.csr2; e.cbus2 = 64'd0;
    end
    return e;
  endfunction

  function automatic in_t rnd();
    in_t t;
    t        = blank();
    t.pc     = {$urandom, $urandom};
    t.inst   = $urandom;
    t.rd     = 5'($urandom);
    t.wgpr   = 1'($urandom);
    t.m2r    = 1'($urandom);
    t.alu    = {$urandom, $urandom};
    t.rdata  = {$urandom, $urandom};
    t.sz     = int'($urandom_range(1, 7));
    t.csr1   = 12'($urandom);
    t.csr2   = 12'($urandom);
    t.wcsr1  = 1'($urandom);
    t.wcsr2  = 1'($urandom);
    t.csrrw  = ($urandom_range(0, 3) == 0);
    t.csrrs  = ($urandom_range(0, 3) == 0);
    t.ecall  = ($urandom_range(0, 7) == 0);
    t.commit = ($urandom_range(0, 3) != 0);
    t.cwdata = {$urandom, $urandom};
    t.crdata = {$urandom, $urandom};
    return t;
  endfunction

  task automatic drive(in_t t, logic v);
    MEM_i_valid       = v;
    MEM_i_pc          = t.pc;
    MEM_i_inst        = t.inst;
    MEM_i_rd          = t.rd;
    MEM_i_write_gpr   = t.wgpr;
    MEM_i_mem_to_reg  = t.m2r;
    MEM_i_alu_result  = t.alu;
    MEM_i_mem_rdata   = t.rdata;
    MEM_i_mem_byte    = (t.sz == 1);
    MEM_i_mem_half    = (t.sz == 2);
    MEM_i_mem_word    = (t.sz == 3);
    MEM_i_mem_dword   = (t.sz == 4);
    MEM_i_mem_byte_u  = (t.sz == 5);
    MEM_i_mem_half_u  = (t.sz == 6);
    MEM_i_mem_word_u  = (t.sz == 7);
    MEM_i_csr_rd_1    = t.csr1;
    MEM_i_csr_rd_2    = t.csr2;
    MEM_i_write_csr_1 = t.wcsr1;
    MEM_i_write_csr_2 = t.wcsr2;
    MEM_i_csr_wdata   = t.cwdata;
    MEM_i_csr_rdata   = t.crdata;
    MEM_i_rv64_csrrw  = t.csrrw;
    MEM_i_rv64_csrrs  = t.csrrs;
    MEM_i_rv64_ecall  = t.ecall;
    MEM_i_system_halt = t.halt;
    MEM_i_commit      = t.commit;
  endtask

  task automatic chk_out(string tag, exp_t e, logic [63:0] cnt);
    chk({tag, " RegWr"},  WB_o_RegWr,      e.regwr);
    chk({tag, " rd"},     WB_o_rd,         e.rd);
    chk({tag, " busW"},   WB_o_rf_busW,    e.busw);
    chk({tag, " CSRWr1"}, WB_o_CSRWr_1,    e.csrwr1);
    chk({tag, " CSRWr2"}, WB_o_CSRWr_2,    e.csrwr2);
    chk({tag, " csr1"},   WB_o_csr_rd_1,   e.csr1);
    chk({tag, " csr2"},   WB_o_csr_rd_2,   e.csr2);
    chk({tag, " cbus1"},  WB_o_csr_busW_1, e.cbus1);
    chk({tag, " cbus2"},  WB_o_csr_busW_2, e.cbus2);
    chk({tag, " commit"}, WB_o_commit,     e.commit);
    chk({tag, " retire"}, WB_o_retire_cnt, cnt);
  endtask

  task automatic chk_idle(string tag);
    chk({tag, " idle RegWr"},  WB_o_RegWr,   1'b0);
    chk({tag, " idle CSRWr1"}, WB_o_CSRWr_1, 1'b0);
    chk({tag, " idle CSRWr2"}, WB_o_CSRWr_2, 1'b0);
    chk({tag, " idle commit"}, WB_o_commit,  1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately
  task automatic pulse_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({tag, " rst ready"},  WB_o_ready,      1'b1);
    chk({tag, " rst halt"},   WB_o_halt,       1'b0);
    chk({tag, " rst retire"}, WB_o_retire_cnt, 64'd0);
    chk({tag, " rst busW"},   WB_o_rf_busW,    64'd0);
    chk({tag, " rst pc"},     WB_o_pc,         64'd0);
    chk_idle({tag, " rst"});
    @(negedge clk);
    rst = 1'b0;
    drive(blank(), 1'b0);
    exp_cnt = 64'd0;
    @(negedge clk);
    chk_idle({tag, " post-rst"});
  endtask

  initial begin
    in_t  t;
    exp_t e;
    in_t  prev;
    logic prev_v;
    logic cv;
    logic [3:0] b2b_commit;

    rst = 1'b1;
    drive(blank(), 1'b0);
    exp_cnt = 64'd0;
    repeat (2) @(negedge clk);
    chk("init ready", WB_o_ready, 1'b1);
    chk("init retire", WB_o_retire_cnt, 64'd0);
    rst = 1'b0;

    // Directed vector table
    t = blank(); t.rd = 5; t.wgpr = 1; t.alu = 64'h1234; t.commit = 1;
    e = noexp(); e.rd = 5; e.regwr = 1; e.busw = 64'h1234; e.commit = 1;
    vecs.push_back('{t, e});
    t.rd = 0; e.rd = 0; e.regwr = 0;
    vecs.push_back('{t, e});
    t = blank(); t.rd = 7; t.wgpr = 1; t.m2r = 1; t.commit = 1;
    t.rdata = 64'h8899AABBCCDDEEFF; t.alu = 64'h1006;
    e = noexp(); e.rd = 7; e.regwr = 1; e.commit = 1;
    t.sz = 1; e.busw = 64'hFFFFFFFFFFFFFF99; vecs.push_back('{t, e});
    t.sz = 5; e.busw = 64'h99;               vecs.push_back('{t, e});
    t.sz = 2; e.busw = 64'hFFFFFFFFFFFF8899; vecs.push_back('{t, e});
    t.sz = 4; e.busw = 64'h8899AABBCCDDEEFF; vecs.push_back('{t, e});
    t.sz = 3; t.alu = 64'h1004; e.busw = 64'hFFFFFFFF8899AABB; vecs.push_back('{t, e});
    t = blank(); t.pc = 64'h80000010; t.ecall = 1; t.commit = 1;
    e = noexp(); e.commit = 1;
    e.csrwr1 = 1; e.csr1 = 12'h341; e.cbus1 = 64'h80000010;
    e.csrwr2 = 1; e.csr2 = 12'h342; e.cbus2 = 64'd11;
    vecs.push_back('{t, e});
    t = blank(); t.rd = 10; t.wgpr = 1; t.csrrw = 1; t.csr1 = 12'h305; t.wcsr1 = 1;
    t.cwdata = 64'h80000100; t.crdata = 64'h7; t.commit = 1;
    e = noexp(); e.rd = 10; e.regwr = 1; e.busw = 64'h7; e.commit = 1;
    e.csrwr1 = 1; e.csr1 = 12'h305; e.cbus1 = 64'h80000100;
    vecs.push_back('{t, e});
    t = blank(); t.rd = 3; t.wgpr = 1; t.alu = 64'h55; t.wcsr1 = 1; t.commit = 0;
    e = noexp(); e.rd = 3; e.busw = 64'h55;
    vecs.push_back('{t, e});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].i, 1'b1);
      if (vecs[i].e.commit) exp_cnt = exp_cnt + 64'd1;
      @(negedge clk);
      drive(blank(), 1'b0);
      chk_out($sformatf("vec%0d", i), vecs[i].e, exp_cnt);
      @(negedge clk);
      chk_idle($sformatf("vec%0d", i));
    end

    // Randomized stream against the reference model
    pulse_reset("rand");
    prev   = blank();
    prev_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (prev_v) chk_out($sformatf("rand%0d", n), model(prev), exp_cnt);
      else        chk_idle($sformatf("rand%0d", n));
      prev   = rnd();
      prev_v = ($urandom_range(0, 3) != 0);
      if (prev_v && prev.commit) exp_cnt = exp_cnt + 64'd1;
      drive(prev, prev_v);
    end
    @(negedge clk);
    drive(blank(), 1'b0);

    // Back-to-back: four transfers, third is a bubble
    pulse_reset("b2b");
    b2b_commit = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      t = blank(); t.rd = 5'(k + 1); t.wgpr = 1; t.alu = 64'(k); t.commit = b2b_commit[k];
      if (k > 0) chk($sformatf("b2b commit%0d", k), WB_o_commit, b2b_commit[k-1]);
      drive(t, 1'b1);
      @(negedge clk);
    end
    drive(blank(), 1'b0);
    chk("b2b commit4", WB_o_commit, b2b_commit[3]);
    chk("b2b retire", WB_o_retire_cnt, 64'd3);
    @(negedge clk);
    chk_idle("b2b end");

    // Halt: ebreak retires, further valid input is ignored
    pulse_reset("halt");
    t = blank(); t.halt = 1; t.commit = 1; t.pc = 64'h80000020;
    drive(t, 1'b1);
    @(negedge clk);
    t = blank(); t.rd = 4; t.wgpr = 1; t.commit = 1;
    drive(t, 1'b1);
    chk("halt ebreak commit", WB_o_commit, 1'b1);
    chk("halt ebreak halt", WB_o_halt, 1'b0);
    chk("halt ebreak retire", WB_o_retire_cnt, 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("halted%0d halt", k), WB_o_halt, 1'b1);
      chk($sformatf("halted%0d ready", k), WB_o_ready, 1'b0);
      chk($sformatf("halted%0d retire", k), WB_o_retire_cnt, 64'd1);
      chk_idle($sformatf("halted%0d", k));
    end
    pulse_reset("unhalt");
    cv = WB_o_ready;
    chk("unhalt ready", cv, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_writeback_stage.md
Name: wb_writeback_stage

Overview:
- Final pipeline stage: registers one retiring instruction from the MEM stage and produces the GPR and CSR write-back buses that the decode stage's register files consume (WB_o_rd, WB_o_RegWr, WB_o_rf_busW, and the two-port CSR write group).
- Performs load-data extraction and extension, GPR/CSR result selection, ecall trap writes, and retire counting.
- Owns the halt state machine.

Parameters:
- BITS_W, 64, data/pc width
- INST_W, 32, instruction width
- GPR_W, 5, GPR index width
- CSR_W, 12, CSR address width
- CSR_MEPC, 12'h341, mepc address
- CSR_MCAUSE, 12'h342, mcause address
- ECALL_CAUSE, 64'd11, mcause value written by ecall

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- MEM_i_valid  in  1  MEM holds a valid instruction
- WB_o_ready  out  1  stage can accept this cycle
- MEM_i_pc  in  BITS_W  instruction pc
- MEM_i_inst  in  INST_W  instruction word
- MEM_i_rd  in  GPR_W  destination GPR
- MEM_i_write_gpr  in  1  instruction writes a GPR
- MEM_i_mem_to_reg  in  1  GPR data comes from the load path
- MEM_i_alu_result  in  BITS_W  ALU result / load address
- MEM_i_mem_rdata  in  BITS_W  raw aligned 64-bit load doubleword
- MEM_i_mem_byte, MEM_i_mem_half, MEM_i_mem_word, MEM_i_mem_dword  in  1 each  signed load size (one-hot with the _u set)
- MEM_i_mem_byte_u, MEM_i_mem_half_u, MEM_i_mem_word_u  in  1 each  unsigned load size
- MEM_i_csr_rd_1, MEM_i_csr_rd_2  in  CSR_W each  CSR write addresses
- MEM_i_write_csr_1, MEM_i_write_csr_2  in  1 each  CSR write enables
- MEM_i_csr_wdata  in  BITS_W  csrrw/csrrs value for port 1
- MEM_i_csr_rdata  in  BITS_W  old CSR value (GPR result of csr instructions)
- MEM_i_rv64_csrrw, MEM_i_rv64_csrrs, MEM_i_rv64_ecall  in  1 each  instruction class
- MEM_i_system_halt  in  1  ebreak/halt
- MEM_i_commit  in  1  instruction is architecturally committed (0 = bubble)
- WB_o_rd  out  GPR_W  GPR write index
- WB_o_RegWr  out  1  GPR write strobe
- WB_o_rf_busW  out  BITS_W  GPR write data
- WB_o_csr_rd_1, WB_o_csr_rd_2  out  CSR_W each  CSR write indices
- WB_o_CSRWr_1, WB_o_CSRWr_2  out  1 each  CSR write strobes
- WB_o_csr_busW_1, WB_o_csr_busW_2  out  BITS_W each  CSR write data
- WB_o_pc, WB_o_inst  out  BITS_W/INST_W  retiring instruction (difftest/trace)
- WB_o_commit  out  1  one-cycle pulse per retired instruction
- WB_o_retire_cnt  out  64  count of retired instructions
- WB_o_halt  out  1  core halted

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active high. On reset, all registered state and all outputs are 0, the FSM is in RUN, and WB_o_ready resets to 1.
- FSM: RUN, HALT.
- Handshake:
  - WB_o_ready = (state == RUN).
  - Transfer occurs when MEM_i_valid && WB_o_ready; payload is captured into the stage register and valid_q <= 1.
  - With no transfer, valid_q <= 0.
  - Outputs are driven from the register: 1-cycle latency from transfer to strobes. Each strobe is high for exactly one cycle per transferred instruction; back-to-back transfers give consecutive strobes.
- GPR write:
  - WB_o_RegWr = valid_q & commit_q & write_gpr_q & (rd_q != 0). A write to x0 is never strobed.
  - WB_o_rf_busW: mem_to_reg_q selects the load data; else (csrrw_q | csrrs_q) selects csr_rdata_q; else alu_result_q.
- Load data:
  - offset = alu_result_q[2:0]. Byte = rdata >> (8*offset); half uses offset[2:1]; word uses offset[2].
  - Signed sizes sign-extend to 64, _u sizes zero-extend, dword passes through.
  - A misaligned half/word takes the lane selected by the truncated offset (no trap).
- CSR write:
  - ecall overrides: CSRWr_1 = 1 with csr_rd_1 = CSR_MEPC and busW_1 = pc_q; CSRWr_2 = 1 with csr_rd_2 = CSR_MCAUSE and busW_2 = ECALL_CAUSE.
  - Otherwise the strobes follow write_csr_1/2 gated by valid_q & commit_q, busW_1 = csr_wdata_q, and busW_2 = 0.
- Commit and retire:
  - WB_o_commit = valid_q & commit_q.
  - retire_cnt increments by 1 on each WB_o_commit and wraps at 2^64.
- Halt:
  - A retiring instruction (valid_q & commit_q & system_halt_q) moves the FSM RUN->HALT at the next edge. That instruction's own writes and commit still occur.
  - In HALT: ready = 0, WB_o_halt = 1, no further transfers, and outputs hold no strobes. HALT exits only via rst.
- Bubble: commit_q = 0 suppresses all strobes and commit; pc/inst still update.
- Reset mid-operation: a pending register write is dropped; nothing is strobed in the cycle after reset deasserts.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, ready = 1, retire_cnt = 0.
- ALU write: transfer rd = 5, write_gpr = 1, alu_result = 64'h1234 -> next cycle RegWr = 1, rd = 5, busW = 64'h1234, commit = 1, retire_cnt = 1; a following idle cycle gives RegWr = 0. Same with rd = 0 -> RegWr = 0 while commit = 1.
- Loads: mem_rdata = 64'h8899AABBCCDDEEFF, addr low bits = 3'd6:
  - lb -> 64'hFFFFFFFFFFFFFF99
  - lbu -> 64'h99
  - lh -> 64'hFFFFFFFFFFFF8899
  - lw at offset 4 -> 64'hFFFFFFFF8899AABB
  - ld -> raw value
- Ecall at pc = 64'h80000010 -> CSRWr_1 = 1 to 12'h341 with data 64'h80000010; CSRWr_2 = 1 to 12'h342 with data 11. csrrw (csr 0x305, wdata 64'h80000100, old value 64'h7) -> CSRWr_1 to 0x305 with 64'h80000100, rf_busW = 7.
- Back-to-back: 4 consecutive valid transfers, third with commit = 0 -> commit pulses on cycles 1, 2, 4 and retire_cnt = 3.
- Halt: ebreak retires -> commit = 1 that cycle, then halt = 1 and ready = 0; subsequent MEM_i_valid is ignored with no strobes; rst restores ready = 1.
